uart_cmd_rcv: RTL and testbench

Command-frame controller that sequences the UART receiver: it consumes each received byte (handshaking via `rx_rdy`/`clr_rx_rdy`), hunts for a sync byte, and assembles a 5-byte frame into one command word. It verifies the frame checksum, enforces an inter-byte timeout, and presents a validated `cmd`/`data` pair to the robot's command-processing logic with a sticky ready flag.

---
 rtl/uart_cmd_rcv.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_rcv.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rcv.sv
// UART command-frame receiver: hunts for SYNC, assembles CMD/DH/DL/CHK,
// verifies the additive checksum and enforces an inter-byte timeout.
module uart_cmd_rcv #(
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    input  logic        clr_cmd_rdy,
    output logic        clr_rx_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    output logic        frame_err,
    output logic        ovr_err,
    output logic        busy
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DH,
        ST_DL,
        ST_CHK
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          tmo_expired;
    logic          timeout_hit;
    logic          frame_ok;
    logic          frame_bad;
    logic [CW-1:0] tmo_cnt;
    logic [7:0]    sum;
    logic [7:0]    cmd_hold;
    logic [7:0]    dh_hold;
    logic [7:0]    dl_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A byte presented while the return pulse is still high is the same byte.
    always_comb begin
        state_next  = state;
        accept      = rx_rdy && !clr_rx_rdy;
        tmo_expired = (tmo_cnt == TO_LAST);
        timeout_hit = 1'b0;
        frame_ok    = 1'b0;
        frame_bad   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && rx_data == SYNC) begin
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (accept) begin
                    state_next = ST_DH;
                end else if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_DH: begin
                if (accept) begin
                    state_next = ST_DL;
                end else if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_DL: begin
                if (accept) begin
                    state_next = ST_CHK;
                end else if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (accept) begin
                    state_next = ST_IDLE;
                    if (rx_data == sum) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end else if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (accept || state_next == ST_IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= 8'h00;
            cmd_hold <= 8'h00;
            dh_hold  <= 8'h00;
            dl_hold  <= 8'h00;
        end else if (accept) begin
            case (state)
                ST_IDLE: sum <= 8'h00;
                ST_CMD: begin
                    cmd_hold <= rx_data;
                    sum      <= sum + rx_data;
                end
                ST_DH: begin
                    dh_hold <= rx_data;
                    sum     <= sum + rx_data;
                end
                ST_DL: begin
                    dl_hold <= rx_data;
                    sum     <= sum + rx_data;
                end
                default: begin
                end
            endcase
        end
    end

    // A completing frame sets cmd_rdy even if the consumer clears it on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_rx_rdy <= 1'b0;
            cmd        <= 8'h00;
            data       <= 16'h0000;
            cmd_rdy    <= 1'b0;
            frame_err  <= 1'b0;
            ovr_err    <= 1'b0;
        end else begin
            clr_rx_rdy <= accept;
            frame_err  <= frame_bad || timeout_hit;
            ovr_err    <= frame_ok && cmd_rdy;
            if (frame_ok) begin
                cmd     <= cmd_hold;
                data    <= {dh_hold, dl_hold};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Directed bench for uart_cmd_rcv using a short timeout so idle scenarios stay brief.
module tb_uart_cmd_rcv;

    localparam int TO = 40;

    logic        clk;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_cmd_rdy;
    logic        clr_rx_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        frame_err;
    logic        ovr_err;
    logic        busy;

    int checks;
    int errors;
    int clr_pulses;
    int ferr_pulses;
    int ovr_pulses;

    uart_cmd_rcv #(.SYNC(8'hA5), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_cmd_rdy (clr_cmd_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .frame_err   (frame_err),
        .ovr_err     (ovr_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (clr_rx_rdy) clr_pulses++;
        if (frame_err)  ferr_pulses++;
        if (ovr_err)    ovr_pulses++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (clr_rx_rdy) got = 1'b1;
        end
        rx_rdy = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL accept_%02h: clr_rx_rdy never pulsed, got %0b expected 1", b, clr_rx_rdy);
        end
    endtask

    task automatic clear_cmd_rdy();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        checks++;
        if (cmd_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cmd_rdy_clear: got %0b expected 0", cmd_rdy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_rdy = 1'b0;
        rx_data = 8'h00;
        clr_cmd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (cmd !== 8'h00) begin errors++; $display("[TB] FAIL reset_cmd: got %h expected 00", cmd); end
        checks++;
        if (data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0000", data); end
        checks++;
        if ({cmd_rdy, frame_err, ovr_err, busy, clr_rx_rdy} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {cmd_rdy, frame_err, ovr_err, busy, clr_rx_rdy});
        end
    endtask

    task automatic test_valid_frame();
        int c0, f0, o0;
        c0 = clr_pulses; f0 = ferr_pulses; o0 = ovr_pulses;
        send_byte(8'hA5);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_sync: got %0b expected 1", busy); end
        send_byte(8'h10);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        checks++;
        if (cmd !== 8'h10 || data !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL valid_cmd_data: got %h/%h expected 10/1234", cmd, data);
        end
        checks++;
        if (cmd_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL valid_rdy_busy: got %0b%0b expected 10", cmd_rdy, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (clr_pulses - c0 != 5) begin
            errors++;
            $display("[TB] FAIL valid_clr_pulses: got %0d expected 5", clr_pulses - c0);
        end
        checks++;
        if (ferr_pulses - f0 != 0 || ovr_pulses - o0 != 0) begin
            errors++;
            $display("[TB] FAIL valid_no_errors: got ferr %0d ovr %0d expected 0 0", ferr_pulses - f0, ovr_pulses - o0);
        end
    endtask

    task automatic test_bad_checksum();
        int f0, o0;
        f0 = ferr_pulses; o0 = ovr_pulses;
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h57);
        repeat (2) @(negedge clk);
        checks++;
        if (ferr_pulses - f0 != 1) begin
            errors++;
            $display("[TB] FAIL badchk_frame_err: got %0d pulses expected 1", ferr_pulses - f0);
        end
        checks++;
        if (cmd !== 8'h10 || data !== 16'h1234 || cmd_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL badchk_hold: got %h/%h/%0b expected 10/1234/1", cmd, data, cmd_rdy);
        end
        checks++;
        if (ovr_pulses - o0 != 0) begin
            errors++;
            $display("[TB] FAIL badchk_ovr: got %0d expected 0", ovr_pulses - o0);
        end
    endtask

    task automatic test_discard();
        int c0, f0, o0;
        clear_cmd_rdy();
        c0 = clr_pulses; f0 = ferr_pulses; o0 = ovr_pulses;
        send_byte(8'h00);
        send_byte(8'hFF);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL discard_busy: got %0b expected 0", busy); end
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h06);
        repeat (2) @(negedge clk);
        checks++;
        if (clr_pulses - c0 != 7) begin
            errors++;
            $display("[TB] FAIL discard_clr_pulses: got %0d expected 7", clr_pulses - c0);
        end
        checks++;
        if (cmd !== 8'h01 || data !== 16'h0203 || cmd_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL discard_frame: got %h/%h/%0b expected 01/0203/1", cmd, data, cmd_rdy);
        end
        checks++;
        if (ferr_pulses - f0 != 0 || ovr_pulses - o0 != 0) begin
            errors++;
            $display("[TB] FAIL discard_errors: got ferr %0d ovr %0d expected 0 0", ferr_pulses - f0, ovr_pulses - o0);
        end
    endtask

    task automatic test_timeout();
        int f0, k;
        bit seen;
        clear_cmd_rdy();
        f0 = ferr_pulses;
        send_byte(8'hA5);
        send_byte(8'h10);
        seen = 1'b0;
        k = 0;
        while (!seen && k < TO + 5) begin
            @(posedge clk);
            #1;
            k++;
            if (frame_err) seen = 1'b1;
        end
        checks++;
        if (!seen || k != TO) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got seen=%0b after %0d cycles expected 1 after %0d", seen, k, TO);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy: got %0b expected 0", busy); end
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h21);
        repeat (2) @(negedge clk);
        checks++;
        if (cmd !== 8'h20 || data !== 16'h0001 || cmd_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_next_frame: got %h/%h/%0b expected 20/0001/1", cmd, data, cmd_rdy);
        end
        checks++;
        if (ferr_pulses - f0 != 1) begin
            errors++;
            $display("[TB] FAIL timeout_pulse_count: got %0d expected 1", ferr_pulses - f0);
        end
    endtask

    task automatic test_timeout_boundary();
        int f0;
        clear_cmd_rdy();
        f0 = ferr_pulses;
        send_byte(8'hA5);
        send_byte(8'h30);
        repeat (TO - 1) @(posedge clk);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h30);
        repeat (2) @(negedge clk);
        checks++;
        if (ferr_pulses - f0 != 0) begin
            errors++;
            $display("[TB] FAIL boundary_frame_err: got %0d pulses expected 0", ferr_pulses - f0);
        end
        checks++;
        if (cmd !== 8'h30 || data !== 16'h0000 || cmd_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL boundary_frame: got %h/%h/%0b expected 30/0000/1", cmd, data, cmd_rdy);
        end
    endtask

    task automatic test_back_to_back_overrun();
        int o0;
        clear_cmd_rdy();
        o0 = ovr_pulses;
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h66);
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_rdy !== 1'b1 || ovr_pulses - o0 != 0) begin
            errors++;
            $display("[TB] FAIL ovr_first: got rdy %0b ovr %0d expected 1 0", cmd_rdy, ovr_pulses - o0);
        end
        send_byte(8'hA5); send_byte(8'h44); send_byte(8'h55); send_byte(8'h66); send_byte(8'hFF);
        repeat (2) @(negedge clk);
        checks++;
        if (cmd !== 8'h44 || data !== 16'h5566 || ovr_pulses - o0 != 1) begin
            errors++;
            $display("[TB] FAIL ovr_second: got %h/%h ovr %0d expected 44/5566 1", cmd, data, ovr_pulses - o0);
        end
        send_byte(8'hA5); send_byte(8'h7F); send_byte(8'h01); send_byte(8'h80);
        @(posedge clk);
        @(negedge clk);
        rx_rdy = 1'b1;
        rx_data = 8'h00;
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        checks++;
        if (clr_rx_rdy !== 1'b1) begin errors++; $display("[TB] FAIL ovr_chk_accept: got %0b expected 1", clr_rx_rdy); end
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== 8'h7F || data !== 16'h0180) begin
            errors++;
            $display("[TB] FAIL set_beats_clear: got %0b %h/%h expected 1 7F/0180", cmd_rdy, cmd, data);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ovr_pulses - o0 != 2) begin
            errors++;
            $display("[TB] FAIL ovr_count: got %0d expected 2", ovr_pulses - o0);
        end
        clear_cmd_rdy();
    endtask

    task automatic test_reset_midframe();
        int f0;
        f0 = ferr_pulses;
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h12);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midframe_busy: got %0b expected 1", busy); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (cmd !== 8'h00 || data !== 16'h0000 || {cmd_rdy, busy, frame_err, ovr_err, clr_rx_rdy} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL midframe_reset: got %h/%h flags %b expected 00/0000 00000",
                     cmd, data, {cmd_rdy, busy, frame_err, ovr_err, clr_rx_rdy});
        end
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        repeat (2) @(negedge clk);
        checks++;
        if (cmd !== 8'h05 || data !== 16'h0000 || cmd_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_reset_frame: got %h/%h/%0b expected 05/0000/1", cmd, data, cmd_rdy);
        end
        checks++;
        if (ferr_pulses - f0 != 0) begin
            errors++;
            $display("[TB] FAIL reset_no_err: got %0d pulses expected 0", ferr_pulses - f0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr_pulses = 0;
        ferr_pulses = 0;
        ovr_pulses = 0;
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_discard();
        test_timeout();
        test_timeout_boundary();
        test_back_to_back_overrun();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
